// File: rtl/spi_tx_sequencer.sv
// SPI transmit sequencer: pops TX FIFO words, hands them to the shift engine and
// frames each transfer with a chip-select using programmable setup, hold and gap timing.
module spi_tx_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SLAVES     = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned IDLE_GAP   = 1,
    localparam int unsigned SEL_W     = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  EN,
    input  logic                  CONT,
    input  logic [SEL_W-1:0]      SLV_SEL,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_EN,
    output logic                  SHIFT_START,
    output logic [DATA_WIDTH-1:0] SHIFT_DATA,
    input  logic                  SHIFT_DONE,
    output logic [SLAVES-1:0]     CS_N,
    output logic                  BUSY,
    output logic                  DONE_IRQ,
    output logic [15:0]           WORD_CNT
);

    typedef enum logic [2:0] {
        StIdle, StPop, StLoad, StSetup, StStart, StWait, StHold, StGap
    } state_e;

    localparam logic [15:0] SetupLast = 16'(CS_SETUP - 1);
    localparam logic [15:0] HoldLast  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GapLast   = 16'(IDLE_GAP - 1);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    cont_q, cont_d;
    logic [DATA_WIDTH-1:0]   shift_data_q;
    logic [15:0]             word_cnt_q;
    logic                    load;
    logic                    inc;
    logic                    sel_ok;
    logic                    cs_active;

    assign sel_ok = int'(SLV_SEL) < int'(SLAVES);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        load    = 1'b0;
        inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (EN && !FIFO_EMPTY && sel_ok) begin
                    sel_d   = SLV_SEL;
                    cont_d  = 1'b0;
                    state_d = StPop;
                end
            end
            StPop: state_d = StLoad;
            StLoad: begin
                load  = 1'b1;
                cnt_d = '0;
                // A continuing word already has CS low, so setup is skipped.
                if (cont_q || CS_SETUP == 0) begin
                    state_d = StStart;
                end else begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (SHIFT_DONE) begin
                    inc   = 1'b1;
                    cnt_d = '0;
                    if (CONT && EN && !FIFO_EMPTY) begin
                        cont_d  = 1'b1;
                        state_d = StPop;
                    end else if (CS_HOLD > 0) begin
                        state_d = StHold;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                cont_d = 1'b0;
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            cnt_q        <= '0;
            cont_q       <= 1'b0;
            shift_data_q <= '0;
            word_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            if (load) shift_data_q <= FIFO_RD_DATA;
            if (inc)  word_cnt_q   <= word_cnt_q + 16'd1;
        end
    end

    // CS is low from LOAD through HOLD, and also in POP when a burst continues.
    assign cs_active = (state_q inside {StLoad, StSetup, StStart, StWait, StHold}) ||
                       (state_q == StPop && cont_q);

    always_comb begin
        CS_N = '1;
        for (int i = 0; i < int'(SLAVES); i++) begin
            CS_N[i] = !(cs_active && int'(sel_q) == i);
        end
    end

    assign FIFO_RD_EN  = (state_q == StPop);
    assign SHIFT_START = (state_q == StStart);
    assign SHIFT_DATA  = shift_data_q;
    assign BUSY        = (state_q != StIdle);
    assign DONE_IRQ    = (state_q == StGap) && (cnt_q == 16'd0);
    assign WORD_CNT    = word_cnt_q;

endmodule
